// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit scheduler: state encoding, byte width
// and the frame-length decode used when a burst is accepted.
package spi_pkg;

  localparam int BYTE_W = 8;
  localparam int LEN_W  = BYTE_W + 1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_FETCH = 3'd2;
  localparam state_t ST_LOAD  = 3'd3;
  localparam state_t ST_SHIFT = 3'd4;
  localparam state_t ST_GAP   = 3'd5;
  localparam state_t ST_HOLD  = 3'd6;

  // A zero frame length stands for a full 256-byte burst.
  function automatic logic [LEN_W-1:0] burst_len(input logic [BYTE_W-1:0] frame_len);
    return (frame_len == '0) ? {1'b1, {BYTE_W{1'b0}}} : {1'b0, frame_len};
  endfunction

endpackage

// File: rtl/spi_tx_sched_if.sv
// Signal bundle between the transmit scheduler and its surroundings: frame
// control, the FIFO read side and the shift-engine handshake.
interface spi_tx_sched_if;
  import spi_pkg::*;

  logic              go;
  logic [BYTE_W-1:0] frame_len;
  logic              abort;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_dout;
  logic              fifo_rde;
  logic              spi_start;
  logic [BYTE_W-1:0] spi_data;
  logic              spi_done;
  logic              cs_n;
  logic              busy;
  logic              frame_done;
  logic              underrun;

  modport master (
    input  go, frame_len, abort, fifo_empty, fifo_dout, spi_done,
    output fifo_rde, spi_start, spi_data, cs_n, busy, frame_done, underrun
  );

  modport slave (
    output go, frame_len, abort, fifo_empty, fifo_dout, spi_done,
    input  fifo_rde, spi_start, spi_data, cs_n, busy, frame_done, underrun
  );

endinterface

// File: rtl/spi_tx_timer.sv
// Loadable down-counter with a zero flag, shared by the setup, gap and hold
// intervals of the transmit scheduler.
module spi_tx_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/spi_tx_sched.sv
// SPI transmit scheduler: frames a burst of FIFO bytes under chip select, one
// pop per byte, with programmable setup, inter-byte gap and hold intervals.
module spi_tx_sched
  import spi_pkg::*;
#(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP      = 1,
  parameter int CNT_W    = 4
) (
  input logic            clk,
  input logic            rstn,
  spi_tx_sched_if.master bus
);

  state_t            state;
  state_t            next_state;
  logic [LEN_W-1:0]  bytes_left;
  logic              go_accept;
  logic              timer_load;
  logic [CNT_W-1:0]  timer_val;
  logic              timer_zero;
  logic              fifo_rde;
  logic              spi_start;
  logic [BYTE_W-1:0] spi_data;
  logic              frame_done;
  logic              underrun;

  assign go_accept = (state == ST_IDLE) && bus.go;

  spi_tx_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Abort never cuts a byte short: LOAD and SHIFT only honour it once spi_done arrives.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (bus.go) next_state = ST_SETUP;
      ST_SETUP: begin
        if (bus.abort)       next_state = ST_HOLD;
        else if (timer_zero) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.abort)            next_state = ST_HOLD;
        else if (!bus.fifo_empty) next_state = ST_LOAD;
      end
      ST_LOAD:  next_state = ST_SHIFT;
      ST_SHIFT: begin
        if (bus.spi_done) begin
          if ((bytes_left == '0) || bus.abort) next_state = ST_HOLD;
          else if (GAP > 0)                    next_state = ST_GAP;
          else                                 next_state = ST_FETCH;
        end
      end
      ST_GAP: begin
        if (bus.abort)       next_state = ST_HOLD;
        else if (timer_zero) next_state = ST_FETCH;
      end
      ST_HOLD:  if (timer_zero) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // The interval timer is reloaded on entry to each timed state.
  always_comb begin
    fifo_rde   = (state == ST_FETCH) && !bus.abort && !bus.fifo_empty;
    timer_load = 1'b0;
    timer_val  = '0;
    if (next_state != state) begin
      case (next_state)
        ST_SETUP: begin
          timer_load = 1'b1;
          timer_val  = CNT_W'(CS_SETUP - 1);
        end
        ST_GAP: begin
          timer_load = 1'b1;
          timer_val  = CNT_W'(GAP - 1);
        end
        ST_HOLD: begin
          timer_load = 1'b1;
          timer_val  = CNT_W'(CS_HOLD - 1);
        end
        default: begin
          timer_load = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bytes_left <= '0;
      spi_data   <= '0;
      spi_start  <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      spi_start  <= (state == ST_LOAD);
      frame_done <= (state == ST_HOLD) && (next_state == ST_IDLE);
      if (go_accept) begin
        bytes_left <= burst_len(bus.frame_len);
        underrun   <= 1'b0;
      end else if (state == ST_LOAD) begin
        spi_data   <= bus.fifo_dout;
        bytes_left <= bytes_left - LEN_W'(1);
      end else if ((state == ST_FETCH) && bus.fifo_empty && !bus.abort) begin
        underrun   <= 1'b1;
      end
    end
  end

  assign bus.fifo_rde   = fifo_rde;
  assign bus.spi_start  = spi_start;
  assign bus.spi_data   = spi_data;
  assign bus.frame_done = frame_done;
  assign bus.underrun   = underrun;
  assign bus.cs_n       = (state == ST_IDLE);
  assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_tx_sched.sv
// Self-checking bench for spi_tx_sched: behavioural FIFO and shifter, a vector
// table, directed corner sequences and randomized frames against a timing model.
module tb_spi_tx_sched;

  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int GAP      = 1;
  localparam int KMAX     = 4000;

  typedef struct {
    int len;
    int delay;
    int preload;
    int exp_starts;
    int exp_fd_k;
    int exp_left;
  } vec_t;

  typedef struct {
    int fd_k;
    int first_rde_k;
    int rde_cnt;
    int start_cnt;
    int fd_cnt;
    int cs_rise_k;
    int ur_first;
    int ur_end;
  } res_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  int checks       = 0;
  int errors       = 0;
  int done_delay   = 8;
  int sh_cnt       = 0;
  int rde_on_empty = 0;

  byte unsigned fifo_q[$];
  byte unsigned model_q[$];
  byte unsigned sent_q[$];
  byte unsigned basic[3];
  vec_t vecs[4];
  res_t r;

  spi_tx_sched_if bus();

  spi_tx_sched #(
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD),
    .GAP      (GAP),
    .CNT_W    (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // FIFO: read data appears the cycle after a read strobe; pushes show up as
  // not-empty from the next rising edge.
  always @(posedge clk) begin
    if (bus.fifo_rde === 1'b1) begin
      if (fifo_q.size() == 0) rde_on_empty++;
      else bus.fifo_dout <= fifo_q.pop_front();
    end
    bus.fifo_empty <= (fifo_q.size() == 0);
  end

  // Shift engine: captures the byte with spi_start, answers done_delay cycles later.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_cnt = 0;
      bus.spi_done <= 1'b0;
    end else begin
      bus.spi_done <= 1'b0;
      if (sh_cnt != 0) begin
        sh_cnt--;
        if (sh_cnt == 0) bus.spi_done <= 1'b1;
      end
      if (bus.spi_start === 1'b1) begin
        sent_q.push_back(bus.spi_data);
        sh_cnt = done_delay - 1;
      end
    end
  end

  // Go-to-frame_done cycle count: setup plus pop cycle, then per byte a load
  // cycle, d shift cycles and a gap+pop before the next; hold after the last.
  function automatic int frameCycles(input int n, input int d);
    return (CS_SETUP + 1) + (n - 1) * (d + GAP + 3) + (d + 2) + (CS_HOLD + 1);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushByte(input byte unsigned b);
    fifo_q.push_back(b);
    model_q.push_back(b);
  endtask

  task automatic flushFifo();
    @(negedge clk);
    fifo_q.delete();
    model_q.delete();
    sent_q.delete();
    @(negedge clk);
  endtask

  task automatic checkSent(input string tag, input int n);
    int bad;
    int first_bad;
    int exp_b;
    int act_b;
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < n; i++) begin
      exp_b = (model_q.size() > 0) ? int'(model_q.pop_front()) : -1;
      act_b = (sent_q.size() > 0) ? int'(sent_q.pop_front()) : -1;
      if (exp_b != act_b) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
    end
    checkOutput($sformatf("%s bytes mismatched (first bad index %0d)", tag, first_bad), bad, 0);
    checkOutput({tag, " extra bytes sent"}, sent_q.size(), 0);
    checkOutput({tag, " fifo level vs model"}, fifo_q.size(), model_q.size());
  endtask

  // Issues go on the current negedge and watches each following cycle (k=1 is
  // the first cycle after go is accepted) until three cycles past frame_done.
  task automatic applyStimulus(input int len, input int abort_on_start, input int late_push_k,
                               input int mid_go_k, output res_t res);
    res = '{fd_k: -1, first_rde_k: -1, rde_cnt: 0, start_cnt: 0, fd_cnt: 0,
            cs_rise_k: -1, ur_first: -1, ur_end: -1};
    bus.frame_len = 8'(len);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    for (int k = 1; k < KMAX; k++) begin
      if (k == 1) res.ur_first = int'(bus.underrun);
      if (bus.fifo_rde === 1'b1) begin
        res.rde_cnt++;
        if (res.first_rde_k < 0) res.first_rde_k = k;
      end
      if (bus.spi_start === 1'b1) begin
        res.start_cnt++;
        if (res.start_cnt == abort_on_start) bus.abort = 1'b1;
      end
      if ((bus.cs_n === 1'b1) && (res.cs_rise_k < 0)) res.cs_rise_k = k;
      if (bus.frame_done === 1'b1) begin
        res.fd_cnt++;
        if (res.fd_k < 0) res.fd_k = k;
      end
      if (k == late_push_k) pushByte(8'($urandom));
      bus.go = (k == mid_go_k);
      if ((res.fd_k >= 0) && (k >= res.fd_k + 3)) break;
      @(negedge clk);
    end
    res.ur_end = int'(bus.underrun);
    bus.abort = 1'b0;
    bus.go = 1'b0;
  endtask

  initial begin
    int idle_bad;
    bus.go        = 1'b1;
    bus.frame_len = 8'd3;
    bus.abort     = 1'b0;
    basic[0] = 8'h54;
    basic[1] = 8'hA5;
    basic[2] = 8'h0F;
    vecs[0] = '{3, 8, 3, 3, 40, 0};
    vecs[1] = '{1, 2, 2, 1, 10, 1};
    vecs[2] = '{4, 5, 6, 4, 40, 2};
    vecs[3] = '{7, 3, 7, 7, 53, 0};

    // Reset held with go asserted: nothing may start.
    repeat (3) @(negedge clk);
    checkOutput("reset cs_n", int'(bus.cs_n), 1);
    checkOutput("reset busy", int'(bus.busy), 0);
    checkOutput("reset fifo_rde", int'(bus.fifo_rde), 0);
    checkOutput("reset spi_start", int'(bus.spi_start), 0);
    checkOutput("reset spi_data", int'(bus.spi_data), 0);
    checkOutput("reset frame_done", int'(bus.frame_done), 0);
    checkOutput("reset underrun", int'(bus.underrun), 0);
    bus.go = 1'b0;
    rstn   = 1'b1;
    idle_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if ((bus.cs_n !== 1'b1) || (bus.busy !== 1'b0) || (bus.fifo_rde !== 1'b0) ||
          (bus.spi_start !== 1'b0) || (bus.frame_done !== 1'b0)) idle_bad++;
    end
    checkOutput("idle cycles off reset values", idle_bad, 0);

    for (int i = 0; i < 4; i++) begin
      flushFifo();
      done_delay = vecs[i].delay;
      for (int j = 0; j < vecs[i].preload; j++) pushByte((i == 0) ? basic[j] : 8'($urandom));
      @(negedge clk);
      applyStimulus(vecs[i].len, 0, -1, -1, r);
      checkOutput($sformatf("vec%0d frame_done cycle", i), r.fd_k, vecs[i].exp_fd_k);
      checkOutput($sformatf("vec%0d cs_n rise cycle", i), r.cs_rise_k, vecs[i].exp_fd_k);
      checkOutput($sformatf("vec%0d first fifo_rde cycle", i), r.first_rde_k, 3);
      checkOutput($sformatf("vec%0d fifo_rde count", i), r.rde_cnt, vecs[i].exp_starts);
      checkOutput($sformatf("vec%0d spi_start count", i), r.start_cnt, vecs[i].exp_starts);
      checkOutput($sformatf("vec%0d frame_done pulses", i), r.fd_cnt, 1);
      checkOutput($sformatf("vec%0d underrun", i), r.ur_end, 0);
      checkOutput($sformatf("vec%0d fifo left", i), fifo_q.size(), vecs[i].exp_left);
      checkSent($sformatf("vec%0d", i), vecs[i].exp_starts);
    end

    // Underrun: second byte arrives while the scheduler waits in FETCH.
    flushFifo();
    done_delay = 8;
    pushByte(8'h3C);
    @(negedge clk);
    applyStimulus(2, 0, 20, -1, r);
    checkOutput("underrun frame_done cycle", r.fd_k, 34);
    checkOutput("underrun spi_start count", r.start_cnt, 2);
    checkOutput("underrun sticky after frame", r.ur_end, 1);
    checkSent("underrun", 2);
    pushByte(8'h77);
    @(negedge clk);
    applyStimulus(1, 0, -1, -1, r);
    checkOutput("underrun cleared by go", r.ur_first, 0);
    checkOutput("underrun clean frame", r.ur_end, 0);
    checkSent("post-underrun", 1);

    // Abort during the second byte's shift: that byte finishes, nothing more is popped.
    flushFifo();
    done_delay = 8;
    for (int j = 0; j < 5; j++) pushByte(8'($urandom));
    @(negedge clk);
    applyStimulus(5, 2, -1, -1, r);
    checkOutput("abort frame_done cycle", r.fd_k, 28);
    checkOutput("abort cs_n rise cycle", r.cs_rise_k, 28);
    checkOutput("abort fifo_rde count", r.rde_cnt, 2);
    checkOutput("abort frame_done pulses", r.fd_cnt, 1);
    checkOutput("abort fifo left", fifo_q.size(), 3);
    checkSent("abort", 2);

    // frame_len 0 is a 256-byte burst; a go in the middle must be ignored.
    flushFifo();
    done_delay = 2;
    for (int j = 0; j < 260; j++) pushByte(8'($urandom));
    @(negedge clk);
    applyStimulus(0, 0, -1, 100, r);
    checkOutput("len256 frame_done cycle", r.fd_k, 1540);
    checkOutput("len256 spi_start count", r.start_cnt, 256);
    checkOutput("len256 fifo_rde count", r.rde_cnt, 256);
    checkOutput("len256 frame_done pulses", r.fd_cnt, 1);
    checkOutput("len256 fifo left", fifo_q.size(), 4);
    checkSent("len256", 256);

    for (int it = 0; it < 6; it++) begin
      int n;
      int d;
      int extra;
      n     = $urandom_range(1, 12);
      d     = $urandom_range(2, 10);
      extra = $urandom_range(0, 3);
      flushFifo();
      done_delay = d;
      for (int j = 0; j < n + extra; j++) pushByte(8'($urandom));
      @(negedge clk);
      applyStimulus(n, 0, -1, -1, r);
      checkOutput($sformatf("rand%0d frame_done cycle (n=%0d d=%0d)", it, n, d), r.fd_k, frameCycles(n, d));
      checkOutput($sformatf("rand%0d spi_start count", it), r.start_cnt, n);
      checkOutput($sformatf("rand%0d frame_done pulses", it), r.fd_cnt, 1);
      checkOutput($sformatf("rand%0d fifo left", it), fifo_q.size(), extra);
      checkSent($sformatf("rand%0d", it), n);
    end

    // Asynchronous reset in the middle of the first byte's shift.
    flushFifo();
    done_delay = 8;
    for (int j = 0; j < 3; j++) pushByte(8'($urandom));
    @(negedge clk);
    bus.frame_len = 8'd3;
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("pre-reset busy", int'(bus.busy), 1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("async reset cs_n", int'(bus.cs_n), 1);
    checkOutput("async reset busy", int'(bus.busy), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    flushFifo();
    pushByte(8'hC3);
    pushByte(8'h1E);
    @(negedge clk);
    applyStimulus(2, 0, -1, -1, r);
    checkOutput("post-reset frame_done cycle", r.fd_k, frameCycles(2, 8));
    checkOutput("post-reset first fifo_rde cycle", r.first_rde_k, 3);
    checkOutput("post-reset spi_start count", r.start_cnt, 2);
    checkSent("post-reset", 2);

    checkOutput("fifo read while empty", rde_on_empty, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_tx_sched.md
Name: spi_tx_sched

Overview:
Transmit scheduler between the synchronous byte FIFO (fifo_sync) and the SPI master shift engine. On a go command it frames a burst of frame_len bytes: it asserts chip select, pops one byte per transfer from the FIFO, hands each byte to the shifter with a start/done handshake, and inserts programmable setup, inter-byte gap and hold times. It stalls on FIFO empty and flags underrun. Instantiated once per SPI master, driving the FIFO read side.

Parameters:
CS_SETUP, 2, clk cycles between cs_n falling and the first FIFO pop (1..15)
CS_HOLD, 2, clk cycles between the last spi_done and cs_n rising (1..15)
GAP, 1, idle clk cycles between a spi_done and the next pop (0..15)
CNT_W, 4, width of the timing counter

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
go  in  1  single-cycle start request; ignored while busy=1
frame_len  in  8  bytes per frame, sampled on accepted go; 0 means 256
abort  in  1  level; ends the frame early (see Behaviour)
fifo_empty  in  1  FIFO empty flag
fifo_dout  in  8  FIFO read data, valid the cycle after a fifo_rde pulse
fifo_rde  out  1  FIFO read enable, single-cycle pulse
spi_start  out  1  single-cycle pulse to shifter; spi_data valid with it
spi_data  out  8  byte to transmit, registered, held until the next load
spi_done  in  1  single-cycle pulse from shifter at end of byte
cs_n  out  1  chip select, active low
busy  out  1  high from accepted go until return to IDLE
frame_done  out  1  single-cycle pulse on the HOLD->IDLE transition
underrun  out  1  sticky; set when FETCH waits on an empty FIFO, cleared on accepted go

Behaviour:
- Reset (rstn=0, async): state IDLE, cs_n=1, busy=0, fifo_rde=0, spi_start=0, spi_data=0, frame_done=0, underrun=0, counters 0. Reset mid-frame abandons it immediately; cs_n rises asynchronously.
- Byte counter bytes_left is 9 bits. On accepted go it loads frame_len, or 256 if frame_len=0.
- States and transitions:
  IDLE: when go=1, load bytes_left, clear underrun, set cs_n=0 and busy=1, load timer=CS_SETUP-1, go to SETUP.
  SETUP: decrement timer; at 0 go to FETCH.
  FETCH: if fifo_empty=1, stay and set underrun. Otherwise pulse fifo_rde for 1 cycle and go to LOAD.
  LOAD (1 cycle): spi_data<=fifo_dout, pulse spi_start, decrement bytes_left, go to SHIFT.
  SHIFT: wait for spi_done. Then go to HOLD (timer=CS_HOLD-1) if bytes_left=0 or abort=1. Otherwise go to GAP (timer=GAP-1) if GAP>0, else go straight to FETCH.
  GAP: decrement timer; at 0 go to FETCH. If abort=1, go to HOLD.
  HOLD: decrement timer; at 0 set cs_n=1, busy=0, pulse frame_done, go to IDLE.
- Abort in SETUP or FETCH: go to HOLD with no pop. Abort in LOAD or SHIFT: the current byte completes first; a byte is never truncated.
- Latency: accepted go to first fifo_rde = CS_SETUP+1 cycles (FIFO non-empty). fifo_rde to spi_start = 1 cycle. spi_done to next fifo_rde = GAP+1 cycles.
- Exactly one pop per transmitted byte. No pop after the last byte, so no data is lost to over-read.
- spi_done outside SHIFT is ignored. go while busy is ignored, with no queuing.
- Simultaneous spi_done and abort in SHIFT go to HOLD. Simultaneous go and frame_done are impossible, because go is only sampled in IDLE.

Decomposition:
- Package spi_pkg holds the state encoding (3-bit localparams ST_IDLE..ST_HOLD) and the BYTE_W=8 constant.
- One natural sub-module: spi_tx_timer, a loadable down-counter with a zero flag, shared by SETUP, GAP and HOLD.
- The FSM and byte counter stay in the top level.

Test Plan:
- Reset and idle: apply and hold rstn low with go=1 -> cs_n=1, busy=0, no fifo_rde. After release with go=0, outputs stay at reset values.
- Basic frame (defaults): FIFO preloaded with 0x54,0xA5,0x0F, frame_len=3, shifter returns spi_done 8 cycles after each spi_start -> 3 fifo_rde pulses, spi_data sequence 54,A5,0F, first fifo_rde 3 cycles after go, cs_n high 2 cycles after the 3rd spi_done, one frame_done pulse, underrun=0.
- Underrun stall: frame_len=2 with one byte in the FIFO; push the second byte 20 cycles later -> controller waits in FETCH, underrun=1 (sticky through frame_done), both bytes sent, underrun cleared by the next go.
- Mid-frame abort: frame_len=5, assert abort during byte 2 SHIFT -> byte 2 completes, no 3rd fifo_rde, cs_n rises CS_HOLD cycles after that spi_done, frame_done pulses once, 3 bytes remain in the FIFO.
- Length 0 = 256: FIFO kept non-empty by the bench, frame_len=0 -> exactly 256 spi_start pulses, then frame_done. A go issued mid-frame is ignored (count unchanged).
- Async reset mid-SHIFT: drop rstn asynchronously -> cs_n=1 and busy=0 without waiting for a clock edge; the next go starts a clean frame.
